// File: rtl/gfx_pkg.sv
// Shared types and helpers for the graphics strip address walker.
// Holds the walker FSM encoding, the coordinate payload and the strip-width shift helper.
package gfx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } gfx_walk_state_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
    } gfx_coord_t;

    // k = log2(256/SW); narrower strips move the mask index further up ndx.
    function automatic int gfx_sw_shift(input int sw);
        case (sw)
            32:      return 3;
            64:      return 2;
            128:     return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/gfx_addr_pipe.sv
// Purpose: 3-stage arithmetic turning a pixel coordinate into strip address and mask fields.
// Latency: 3 clocks from an accepted coordinate to its beat on the output registers.
// Backpressure: a held output beat (beat_vld && !beat_rdy) freezes every stage together.
module gfx_addr_pipe
    import gfx_pkg::*;
#(
    parameter int SW = 256,
    parameter int BN = $clog2(SW) - 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        coord_vld,
    output logic        coord_rdy,
    input  gfx_coord_t  coord_dat,
    input  logic [31:0] base,
    input  logic [15:0] coeff1,
    input  logic [9:0]  coeff2,
    input  logic [5:0]  bpp,
    input  logic [5:0]  cbpp,
    input  logic [9:0]  num_strips,
    input  logic        beat_rdy,
    output logic        beat_vld,
    output logic [31:0] beat_addr,
    output logic [BN:0] beat_mb,
    output logic [BN:0] beat_me,
    output logic [BN:0] beat_ce,
    output gfx_coord_t  beat_coord,
    output logic        busy
);

    localparam int K  = gfx_sw_shift(SW);
    localparam int AS = $clog2(SW) - 3;
    localparam int MW = BN + 1;

    logic        adv;
    logic        s1_vld;
    logic [25:0] s1_p;
    gfx_coord_t  s1_c;
    logic        s2_vld;
    logic [9:0]  s2_strip;
    logic [25:0] s2_row;
    logic [BN:0] s2_mb;
    gfx_coord_t  s2_c;

    logic [25:0] p_c;
    logic [8:0]  fract_hi;
    logic [17:0] prod;
    logic [17:0] ndx;
    logic [BN:0] mb_c;
    logic [25:0] row_c;
    logic [31:0] addr_c;
    logic [BN:0] me_c;
    logic [BN:0] ce_c;

    assign adv       = !(beat_vld && !beat_rdy);
    assign coord_rdy = adv;
    assign busy      = s1_vld | s2_vld | beat_vld;

    // Only bits [25:0] of x*coeff1 ever matter (strip and fraction).
    assign p_c      = {10'd0, coord_dat.x} * {10'd0, coeff1};
    // Round the fraction up by one strip minus a bit before taking its top 9 bits.
    assign fract_hi = 9'((s1_p[15:0] + 16'(SW - 1)) >> 7);
    assign prod     = {9'd0, fract_hi} * {8'd0, coeff2};
    assign ndx      = prod << K;
    assign mb_c     = MW'(ndx >> (9 + K));
    assign row_c    = {16'd0, num_strips} * {10'd0, s1_c.y};

    assign addr_c = base + (({6'd0, s2_row} + {22'd0, s2_strip}) << AS);
    assign me_c   = s2_mb + MW'(bpp);
    assign ce_c   = s2_mb + MW'(cbpp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s1_p       <= '0;
            s1_c       <= '0;
            s2_vld     <= 1'b0;
            s2_strip   <= '0;
            s2_row     <= '0;
            s2_mb      <= '0;
            s2_c       <= '0;
            beat_vld   <= 1'b0;
            beat_addr  <= '0;
            beat_mb    <= '0;
            beat_me    <= '0;
            beat_ce    <= '0;
            beat_coord <= '0;
        end else if (flush) begin
            s1_vld   <= 1'b0;
            s2_vld   <= 1'b0;
            beat_vld <= 1'b0;
        end else if (adv) begin
            s1_vld     <= coord_vld;
            s1_p       <= p_c;
            s1_c       <= coord_dat;
            s2_vld     <= s1_vld;
            s2_strip   <= s1_p[25:16];
            s2_row     <= row_c;
            s2_mb      <= mb_c;
            s2_c       <= s1_c;
            beat_vld   <= s2_vld;
            beat_addr  <= addr_c;
            beat_mb    <= s2_mb;
            beat_me    <= me_c;
            beat_ce    <= ce_c;
            beat_coord <= s2_c;
        end
    end

endmodule

// File: rtl/gfx_addr_walker.sv
// Purpose: walks a pixel rectangle in raster order and emits one strip address/mask beat per pixel.
// Latency: first beat 4 clocks after the accepting start edge, then 1 beat per clock.
// Backpressure: valid/ready; a held beat stalls the walker and all pipeline stages.
module gfx_addr_walker
    import gfx_pkg::*;
#(
    parameter int SW = 256,
    parameter int BN = $clog2(SW) - 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] base_address_i,
    input  logic [15:0] coeff1_i,
    input  logic [9:0]  coeff2_i,
    input  logic [5:0]  bpp_i,
    input  logic [5:0]  cbpp_i,
    input  logic [15:0] bmp_width_i,
    input  logic [15:0] x0_i,
    input  logic [15:0] y0_i,
    input  logic [15:0] x1_i,
    input  logic [15:0] y1_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] address_o,
    output logic [BN:0] mb_o,
    output logic [BN:0] me_o,
    output logic [BN:0] ce_o,
    output logic [15:0] x_o,
    output logic [15:0] y_o,
    output logic        last_o,
    output logic        busy_o,
    output logic        done_o
);

    gfx_walk_state_t state_q, state_d;

    logic [31:0] base_q;
    logic [15:0] coeff1_q;
    logic [9:0]  coeff2_q;
    logic [5:0]  bpp_q, cbpp_q;
    logic [15:0] width_q;
    logic [15:0] x0_q, y0_q, x1_q, y1_q;
    logic [15:0] cur_x, cur_y;
    logic [9:0]  num_strips;
    logic        done_q;

    logic        accept, flush, empty_rect, issue_last, hs_last;
    logic        issue_vld, issue_rdy, done_set, pipe_busy;
    gfx_coord_t  issue_dat, beat_coord;

    assign accept     = start_i && !abort_i && (state_q == IDLE);
    assign flush      = abort_i && (state_q != IDLE);
    assign empty_rect = (x1_q < x0_q) || (y1_q < y0_q);
    assign issue_last = (cur_x == x1_q) && (cur_y == y1_q);
    assign hs_last    = valid_o && ready_i && last_o;

    assign issue_dat.x    = cur_x;
    assign issue_dat.y    = cur_y;
    assign issue_dat.last = issue_last;

    always_comb begin
        state_d   = state_q;
        issue_vld = 1'b0;
        done_set  = 1'b0;
        case (state_q)
            IDLE:  if (accept) state_d = SETUP;
            SETUP: state_d = empty_rect ? DRAIN : RUN;
            RUN: begin
                issue_vld = 1'b1;
                if (issue_rdy && issue_last) state_d = DRAIN;
            end
            // An empty rectangle reaches DRAIN with nothing in flight and leaves at once.
            DRAIN: begin
                if (hs_last || !pipe_busy) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d   = IDLE;
            issue_vld = 1'b0;
            done_set  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            base_q     <= '0;
            coeff1_q   <= '0;
            coeff2_q   <= '0;
            bpp_q      <= '0;
            cbpp_q     <= '0;
            width_q    <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            num_strips <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_set;
            if (accept) begin
                base_q   <= base_address_i;
                coeff1_q <= coeff1_i;
                coeff2_q <= coeff2_i;
                bpp_q    <= bpp_i;
                cbpp_q   <= cbpp_i;
                width_q  <= bmp_width_i;
                x0_q     <= x0_i;
                y0_q     <= y0_i;
                x1_q     <= x1_i;
                y1_q     <= y1_i;
                cur_x    <= x0_i;
                cur_y    <= y0_i;
            end
            if (state_q == SETUP) begin
                num_strips <= 10'(({16'd0, width_q} * {16'd0, coeff1_q}) >> 16);
            end
            if (issue_vld && issue_rdy && !issue_last) begin
                if (cur_x == x1_q) begin
                    cur_x <= x0_q;
                    cur_y <= cur_y + 16'd1;
                end else begin
                    cur_x <= cur_x + 16'd1;
                end
            end
        end
    end

    gfx_addr_pipe #(
        .SW (SW),
        .BN (BN)
    ) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .coord_vld  (issue_vld),
        .coord_rdy  (issue_rdy),
        .coord_dat  (issue_dat),
        .base       (base_q),
        .coeff1     (coeff1_q),
        .coeff2     (coeff2_q),
        .bpp        (bpp_q),
        .cbpp       (cbpp_q),
        .num_strips (num_strips),
        .beat_rdy   (ready_i),
        .beat_vld   (valid_o),
        .beat_addr  (address_o),
        .beat_mb    (mb_o),
        .beat_me    (me_o),
        .beat_ce    (ce_o),
        .beat_coord (beat_coord),
        .busy       (pipe_busy)
    );

    assign x_o    = beat_coord.x;
    assign y_o    = beat_coord.y;
    assign last_o = beat_coord.last;
    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_gfx_addr_walker.sv
// Directed bench for gfx_addr_walker: expected beats are queued at start and popped on handshakes.
module tb_gfx_addr_walker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, abort_i, ready_i;
    logic [31:0] base_address_i;
    logic [15:0] coeff1_i;
    logic [9:0]  coeff2_i;
    logic [5:0]  bpp_i, cbpp_i;
    logic [15:0] bmp_width_i, x0_i, y0_i, x1_i, y1_i;
    logic        valid_o, last_o, busy_o, done_o;
    logic [31:0] address_o;
    logic [7:0]  mb_o, me_o, ce_o;
    logic [15:0] x_o, y_o;

    logic [88:0] obs_v;
    logic [88:0] sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc, first_vld, done_cyc, last_hs, pops;
    logic        done_busy, stall_prev, quiet;
    logic [89:0] held;

    always #5 clk = ~clk;

    gfx_addr_walker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .base_address_i (base_address_i),
        .coeff1_i       (coeff1_i),
        .coeff2_i       (coeff2_i),
        .bpp_i          (bpp_i),
        .cbpp_i         (cbpp_i),
        .bmp_width_i    (bmp_width_i),
        .x0_i           (x0_i),
        .y0_i           (y0_i),
        .x1_i           (x1_i),
        .y1_i           (y1_i),
        .ready_i        (ready_i),
        .valid_o        (valid_o),
        .address_o      (address_o),
        .mb_o           (mb_o),
        .me_o           (me_o),
        .ce_o           (ce_o),
        .x_o            (x_o),
        .y_o            (y_o),
        .last_o         (last_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    assign obs_v = {address_o, mb_o, me_o, ce_o, x_o, y_o, last_o};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic for SW=256 (k=0, 32-byte strips, 8-bit mask fields).
    function automatic logic [88:0] model(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p, ns, ndx, addr;
        logic [15:0] fr;
        logic [7:0]  mb, me, ce;
        p    = {16'd0, x} * {16'd0, coeff1_i};
        ns   = (({16'd0, bmp_width_i} * {16'd0, coeff1_i}) >> 16) & 32'h3FF;
        fr   = p[15:0] + 16'd255;
        ndx  = ({23'd0, fr[15:7]} * {22'd0, coeff2_i}) & 32'h3FFFF;
        mb   = ndx[16:9];
        me   = mb + {2'd0, bpp_i};
        ce   = mb + {2'd0, cbpp_i};
        addr = base_address_i + ((ns * {16'd0, y} + {22'd0, p[25:16]}) << 5);
        return {addr, mb, me, ce, x, y, (x == x1_i) && (y == y1_i)};
    endfunction

    function automatic logic rdy_of(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 3 == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic set_ops(input logic [31:0] b, input logic [15:0] c1, input logic [9:0] c2,
                           input logic [5:0] bp, input logic [5:0] cbp, input logic [15:0] w);
        base_address_i = b;
        coeff1_i       = c1;
        coeff2_i       = c2;
        bpp_i          = bp;
        cbpp_i         = cbp;
        bmp_width_i    = w;
    endtask

    task automatic push_rect(input logic [15:0] ax0, input logic [15:0] ay0,
                             input logic [15:0] ax1, input logic [15:0] ay1);
        x0_i = ax0; y0_i = ay0; x1_i = ax1; y1_i = ay1;
        if (ax1 >= ax0 && ay1 >= ay0) begin
            for (int yy = int'(ay0); yy <= int'(ay1); yy++)
                for (int xx = int'(ax0); xx <= int'(ax1); xx++)
                    sb.push_back(model(16'(xx), 16'(yy)));
        end
    endtask

    task automatic begin_walk();
        first_vld = -1; done_cyc = -1; last_hs = -1; pops = 0;
        stall_prev = 1'b0; done_busy = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 0;
    endtask

    // One clock: evaluate the outputs of the current cycle, then advance past the next edge.
    task automatic cycle(input logic rdy);
        logic [88:0] exp_b;
        ready_i = rdy;
        if (stall_prev) chk("stall_hold", 128'({valid_o, obs_v}), 128'(held));
        if (valid_o && rdy) begin
            if (sb.size() == 0) begin
                chk("extra_beat", 128'(valid_o), 128'(0));
            end else begin
                exp_b = sb.pop_front();
                chk("beat", 128'(obs_v), 128'(exp_b));
                pops++;
                if (exp_b[0]) last_hs = cyc;
            end
        end
        if (valid_o && first_vld < 0) first_vld = cyc;
        if (done_o && done_cyc < 0) begin
            done_cyc  = cyc;
            done_busy = busy_o;
        end
        stall_prev = valid_o && !rdy;
        held       = {valid_o, obs_v};
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run_walk(input string tag, input int mode,
                            input logic [15:0] ax0, input logic [15:0] ay0,
                            input logic [15:0] ax1, input logic [15:0] ay1);
        logic empty;
        empty = (ax1 < ax0) || (ay1 < ay0);
        push_rect(ax0, ay0, ax1, ay1);
        begin_walk();
        chk({tag, "_busy_after_start"}, 128'(busy_o), 128'(1));
        while (done_cyc < 0 && cyc < 300) cycle(rdy_of(mode, cyc));
        chk({tag, "_done_cycle"}, 128'(done_cyc), empty ? 128'(2) : 128'(last_hs + 1));
        chk({tag, "_first_valid_cycle"}, 128'(first_vld), empty ? 128'(-1) : 128'(4));
        chk({tag, "_beats_left"}, 128'(sb.size()), 128'(0));
        chk({tag, "_busy_at_done"}, 128'(done_busy), 128'(0));
        chk({tag, "_after_done"}, 128'({done_o, busy_o, valid_o}), 128'(0));
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1;
        set_ops(32'h0, 16'h0, 10'h0, 6'h0, 6'h0, 16'h0);
        x0_i = '0; y0_i = '0; x1_i = '0; y1_i = '0;
        #12;
        chk("reset_outputs", 128'({valid_o, busy_o, done_o, obs_v}), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        set_ops(32'h1000, 16'h0800, 10'd8, 6'd7, 6'd7, 16'd640);
        run_walk("rect4", 0, 16'd0, 16'd0, 16'd3, 16'd0);
        run_walk("row1", 0, 16'd0, 16'd1, 16'd0, 16'd1);
        run_walk("stall2x2", 1, 16'd0, 16'd0, 16'd1, 16'd1);
        run_walk("empty", 0, 16'd3, 16'd0, 16'd1, 16'd0);

        set_ops(32'hFFFF_FF00, 16'h2000, 10'h155, 6'd3, 6'd15, 16'd100);
        run_walk("wrap_rand", 2, 16'd5, 16'd2, 16'd9, 16'd3);

        // Abort while the second beat of an 8-pixel row is on the output.
        set_ops(32'h1000, 16'h0800, 10'd8, 6'd7, 6'd7, 16'd640);
        push_rect(16'd0, 16'd0, 16'd7, 16'd0);
        begin_walk();
        while (!(valid_o && pops == 1) && cyc < 50) cycle(1'b1);
        chk("abort_second_beat", 128'({valid_o, x_o}), 128'({1'b1, 16'd1}));
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        chk("abort_next_cycle", 128'({valid_o, busy_o}), 128'(0));
        sb.delete();
        quiet = 1'b1;
        repeat (10) begin
            if (done_o || valid_o) quiet = 1'b0;
            @(posedge clk); #1;
        end
        chk("abort_no_done", 128'(quiet), 128'(1));
        run_walk("after_abort", 0, 16'd0, 16'd0, 16'd3, 16'd0);

        // Asynchronous reset in the middle of a walk.
        push_rect(16'd0, 16'd0, 16'd3, 16'd0);
        begin_walk();
        while (cyc < 5) cycle(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_walk", 128'({valid_o, busy_o, done_o, obs_v}), 128'(0));
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            if (done_o || valid_o || busy_o) quiet = 1'b0;
            @(posedge clk); #1;
        end
        chk("reset_quiet", 128'(quiet), 128'(1));
        run_walk("after_reset", 0, 16'd0, 16'd0, 16'd3, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
